regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised successor to the processor register file: N-entry, W-bit storage with a configurable number of combinational read ports, two write ports (pipeline writeback and long-latency multdiv writeback) and a per-register busy scoreboard. Issue of a long-latency op marks its destination busy; the multdiv writeback clears it. Per-port busy flags and a combined `stall` drive the decode-stage interlock. Register 0 is hardwired to zero and never busy.

## Interface
- `DATA_W`, 32, register width in bits
- `NUM_REGS`, 32, register count; power of two, ≥ 4
- `RD_PORTS`, 2, number of read ports, 1–4
- `MAX_PENDING`, 2, maximum outstanding long-latency ops, 1–7
- `ADDR_W`, localparam, `$clog2(NUM_REGS)`

Clock: one clock; reset is synchronous and active-high.
- `clock`  in  1  rising-edge clock for all state
- `ctrl_reset`  in  1  synchronous, active-high; clears all registers, busy bits, pending count and `issue_err`
- `ctrl_writeEnable`  in  1  primary (pipeline) write strobe
- `ctrl_writeReg`  in  ADDR_W  primary write address
- `data_writeReg`  in  DATA_W  primary write data
- `ctrl_mdWriteEnable`  in  1  multdiv writeback strobe; also clears busy
- `ctrl_mdWriteReg`  in  ADDR_W  multdiv write address
- `data_mdWriteReg`  in  DATA_W  multdiv write data
- `ctrl_issueEnable`  in  1  long-latency op issued this cycle
- `ctrl_issueReg`  in  ADDR_W  destination of issued op
- `ctrl_readReg`  in  RD_PORTS*ADDR_W  packed read addresses, port p at `[p*ADDR_W +: ADDR_W]`
- `data_readReg`  out  RD_PORTS*DATA_W  packed read data, same packing
- `busy_readReg`  out  RD_PORTS  busy flag of each addressed register
- `stall`  out  1  OR of `busy_readReg`
- `issue_ready`  out  1  an issue this cycle will be accepted
- `issue_err`  out  1  sticky; an issue was attempted while `issue_ready` was low

## Operation
- Writes take effect at the rising edge. Writes to reg 0 are ignored.
- Both write ports target the same register in the same cycle: primary data is stored. The busy bit is still cleared by the md write.
- Busy vector `busy[NUM_REGS-1:1]` and a 3-bit `pending` counter.
  - An accepted issue sets `busy[r]` and increments `pending`.
  - An md write to a busy `r` clears `busy[r]` and decrements `pending`.
  - An md write to a non-busy register writes data and leaves `pending` unchanged.
- `issue_ready` = `pending < MAX_PENDING` and `!busy[ctrl_issueReg]`.
  - An issue to reg 0 is accepted as a no-op: no busy bit, no count change.
  - An issue while not ready is dropped and sets `issue_err`.
- Issue and md clear on the same register in the same cycle: the bit stays set and `pending` is unchanged.
- Issue and md clear on different registers in the same cycle: `pending` is unchanged, and `issue_ready` evaluates against the pre-edge count.
- Reads are combinational from the stored array. Reg 0 reads 0 with busy 0.
- `ctrl_reset` has priority over all same-cycle writes and issues. Outstanding ops are forgotten; later md writes to non-busy registers write data only.

## Timing
- Reset values:
  - all registers 0;
  - `busy` all 0 and `pending` 0;
  - `issue_err` 0;
  - `issue_ready` 1 and `stall` 0.
- Write latency: data is visible on reads the cycle after the write edge, or the same cycle when bypass is enabled (see Configuration).
- Busy set latency: `busy_readReg` asserts the cycle after the issue edge.
- Busy clear latency: one cycle after the md write, or the same cycle with bypass enabled.
- `pending` never underflows or overflows. Saturation is guaranteed by `issue_ready` gating.

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle write-to-read forwarding.
  - A read matching an active write address returns the write data. If both ports match, primary data wins.
  - A read matching an active md write shows busy 0 in that cycle.
  - Reg 0 is never forwarded.
- `REGFILE_BYPASS_EN` undefined: reads return stored state only, and busy clears one cycle after the md write.

## Structure
- `regfile_pkg` holds the defaults `DATA_W_DEF` and `NUM_REGS_DEF`, the `ADDR_W` function, and the packed-port index helpers.
- Sub-module `regfile_bank` holds the storage array with two prioritised write ports and hardwired reg 0.
- Scoreboard, counter, read muxing and bypass live in the top module.

## Test plan
- Reset, then write 0xDEADBEEF to r5 on the primary port; read r5 next cycle → 0xDEADBEEF. Write 0x1 to r0; read r0 → 0.
- Issue r7 → `busy_readReg` = 1 on a port reading r7 next cycle, and `stall` = 1. md write 0x55 to r7 → busy 0 and read 0x55: same cycle with the macro, next cycle without it.
- `MAX_PENDING`=2: issue r3, then r4, then r6 → third issue sees `issue_ready` = 0, is dropped, `issue_err` = 1; `busy[6]` = 0.
- Same cycle: primary write 0xA and md write 0xB to r9 with r9 busy → r9 = 0xA, busy[9] = 0, `pending` decremented.
- Same cycle: issue r2 and md clear r2 → busy[2] stays 1 and `pending` is unchanged. Then assert `ctrl_reset` mid-flight → all busy 0, `pending` 0, `issue_err` 0, registers 0.
- Issue r8 while r8 is already busy → dropped, `issue_err` = 1, `pending` unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the scoreboarded register file:
//   - DATA_W_DEF / NUM_REGS_DEF : default register width and count
//   - PENDING_W                 : width of the outstanding long-latency op counter
//   - addr_w()                  : register address width for a given register count
//   - port_lo() / port_hi()     : bit bounds of one port inside a packed multi-port bus
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int PENDING_W    = 3;

  function automatic int addr_w(input int num_regs);
    return $clog2(num_regs);
  endfunction

  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

  function automatic int port_hi(input int port, input int width);
    return (port + 1) * width - 1;
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// regfile_bank
//   Storage array for the register file. Two write ports share the array;
//   when both target the same register in one cycle the primary port's data
//   is stored. Register 0 has no storage and always reads as zero.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high clear of all registers
//   we/waddr/wdata    primary (pipeline writeback) write port
//   md_we/md_addr/md_data  multdiv writeback write port
//   regs              every register flattened, register i at [i*DATA_W +: DATA_W]
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DATA_W_DEF,
  parameter int  NUM_REGS = NUM_REGS_DEF,
  localparam int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       md_we,
  input  logic [ADDR_W-1:0]          md_addr,
  input  logic [DATA_W-1:0]          md_data,
  output logic [NUM_REGS*DATA_W-1:0] regs
);

  logic [DATA_W-1:0] mem [1:NUM_REGS-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (md_we && (md_addr != '0)) begin
        mem[md_addr] <= md_data;
      end
      // Issued after the md write so the primary port wins a same-register collision.
      if (we && (waddr != '0)) begin
        mem[waddr] <= wdata;
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs[port_lo(i, DATA_W) +: DATA_W] = mem[i];
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   N-entry register file with RD_PORTS combinational read ports, a primary
//   and a multdiv write port, and a per-register busy scoreboard for
//   long-latency operations. Register 0 reads zero and is never busy.
//   Optional feature macro: REGFILE_BYPASS_EN -- same-cycle write-to-read
//   forwarding of data and of busy clears.
// Ports:
//   clock, ctrl_reset                     clock and synchronous active-high reset
//   ctrl_writeEnable/writeReg, data_writeReg      primary write port
//   ctrl_mdWriteEnable/mdWriteReg, data_mdWriteReg multdiv write port (clears busy)
//   ctrl_issueEnable, ctrl_issueReg       long-latency op issue (sets busy)
//   ctrl_readReg / data_readReg           packed read addresses / read data
//   busy_readReg, stall                   per-port busy flags and their OR
//   issue_ready, issue_err                issue acceptance and sticky drop flag
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  DATA_W      = DATA_W_DEF,
  parameter int  NUM_REGS    = NUM_REGS_DEF,
  parameter int  RD_PORTS    = 2,
  parameter int  MAX_PENDING = 2,
  localparam int ADDR_W      = addr_w(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       ctrl_reset,
  input  logic                       ctrl_writeEnable,
  input  logic [ADDR_W-1:0]          ctrl_writeReg,
  input  logic [DATA_W-1:0]          data_writeReg,
  input  logic                       ctrl_mdWriteEnable,
  input  logic [ADDR_W-1:0]          ctrl_mdWriteReg,
  input  logic [DATA_W-1:0]          data_mdWriteReg,
  input  logic                       ctrl_issueEnable,
  input  logic [ADDR_W-1:0]          ctrl_issueReg,
  input  logic [RD_PORTS*ADDR_W-1:0] ctrl_readReg,
  output logic [RD_PORTS*DATA_W-1:0] data_readReg,
  output logic [RD_PORTS-1:0]        busy_readReg,
  output logic                       stall,
  output logic                       issue_ready,
  output logic                       issue_err
);

  logic [NUM_REGS*DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]        busy;
  logic [PENDING_W-1:0]       pending;
  logic                       md_clr;
  logic                       md_frees_issue;
  logic                       issue_set;

  regfile_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .clock   (clock),
    .reset   (ctrl_reset),
    .we      (ctrl_writeEnable),
    .waddr   (ctrl_writeReg),
    .wdata   (data_writeReg),
    .md_we   (ctrl_mdWriteEnable),
    .md_addr (ctrl_mdWriteReg),
    .md_data (data_mdWriteReg),
    .regs    (regs)
  );

  // Scoreboard control. busy[0] is never set, so md writes to r0 never clear
  // anything and issues to r0 never occupy a slot.
  always_comb begin
    md_clr         = ctrl_mdWriteEnable && busy[ctrl_mdWriteReg];
    // A register being retired this cycle may be re-issued in the same cycle:
    // the retire and the new issue cancel in the counter and the bit stays set.
    md_frees_issue = md_clr && (ctrl_mdWriteReg == ctrl_issueReg);
    // The count compared is the pre-edge value, even when an md write retires
    // a different register in the same cycle.
    issue_ready    = (int'(pending) < MAX_PENDING) &&
                     (!busy[ctrl_issueReg] || md_frees_issue);
    issue_set      = ctrl_issueEnable && issue_ready && (ctrl_issueReg != '0);
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      busy      <= '0;
      pending   <= '0;
      issue_err <= 1'b0;
    end else begin
      if (md_clr) begin
        busy[ctrl_mdWriteReg] <= 1'b0;
      end
      // Placed after the clear so a same-register retire/re-issue leaves the bit set.
      if (issue_set) begin
        busy[ctrl_issueReg] <= 1'b1;
      end
      case ({issue_set, md_clr})
        2'b10:   pending <= pending + 3'd1;
        2'b01:   pending <= pending - 3'd1;
        default: pending <= pending;
      endcase
      if (ctrl_issueEnable && !issue_ready) begin
        issue_err <= 1'b1;
      end
    end
  end

  // Read ports
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              bs;

    always_comb begin
      ra = ctrl_readReg[port_lo(p, ADDR_W) +: ADDR_W];
      rd = regs[int'(ra) * DATA_W +: DATA_W];
      bs = busy[ra];
`ifdef REGFILE_BYPASS_EN
      if (ra != '0) begin
        if (ctrl_writeEnable && (ctrl_writeReg == ra)) begin
          rd = data_writeReg;
        end else if (ctrl_mdWriteEnable && (ctrl_mdWriteReg == ra)) begin
          rd = data_mdWriteReg;
        end
        if (ctrl_mdWriteEnable && (ctrl_mdWriteReg == ra)) begin
          bs = 1'b0;
        end
      end
`endif
    end

    assign data_readReg[port_lo(p, DATA_W) +: DATA_W] = rd;
    assign busy_readReg[p]                            = bs;
  end

  assign stall = |busy_readReg;

endmodule
